// File: rtl/fetch_buffer.sv
// Pairs each accepted fetch PC with the next-cycle memory word and queues {pc, instr} for decode.
// Fetch-to-decode latency is two cycles; stall_out holds the PC while queued plus in-flight fetches fill DEPTH.
module fetch_buffer #(
   parameter int PC_WIDTH    = 32,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [PC_WIDTH-1:0]    pc_in,
   input  logic                   pc_in_valid,
   input  logic [INSTR_WIDTH-1:0] instr_in,
   input  logic                   flush,
   output logic                   stall_out,
   output logic                   dec_valid,
   input  logic                   dec_ready,
   output logic [PC_WIDTH-1:0]    dec_pc,
   output logic [INSTR_WIDTH-1:0] dec_instr
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   typedef struct packed {
      logic [PC_WIDTH-1:0]    pc;
      logic [INSTR_WIDTH-1:0] instr;
   } entry_t;

   entry_t              r_mem [DEPTH];
   logic [AW-1:0]       r_wptr;
   logic [AW-1:0]       r_rptr;
   logic [CW-1:0]       r_count;
   logic                r_inflight;
   logic [PC_WIDTH-1:0] r_pend_pc;

   logic                w_acc;
   logic                w_wr;
   logic                w_deq;
   logic [CW:0]         w_occ;
   entry_t              w_head;

   // The in-flight fetch already owns a slot, so it counts toward occupancy.
   assign w_occ     = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
   assign stall_out = ~flush & (w_occ >= (CW + 1)'(DEPTH));
   assign dec_valid = (r_count != '0) & ~flush;

   assign w_acc  = pc_in_valid & ~stall_out & ~flush;
   assign w_wr   = r_inflight & ~flush;
   assign w_deq  = dec_valid & dec_ready;
   assign w_head = r_mem[r_rptr];

   assign dec_pc    = dec_valid ? w_head.pc    : '0;
   assign dec_instr = dec_valid ? w_head.instr : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
         r_pend_pc  <= '0;
      end else if (flush) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_count    <= '0;
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_acc;
         if (w_acc) begin
            r_pend_pc <= pc_in;
         end
         if (w_wr) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_deq) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + CW'(w_wr) - CW'(w_deq);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && w_wr) begin
         r_mem[r_wptr] <= '{pc: r_pend_pc, instr: instr_in};
      end
   end

   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(w_wr && r_count == CW'(DEPTH)));

endmodule
